hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the 5-stage core. It consumes the forwarding codes from the forwarding unit, plus the EX-stage redirect and data-memory ready signals. From these it produces the per-stage write enables, bubble and flush controls, and three performance counters. Code 2'b11 on any forward output means "producer is a load one stage ahead, value not yet available". hazard_ctrl resolves that case with a one-cycle stall, after which forwarding naturally switches to 2'b10.

## Interface
- CNT_W, 32, width of each performance counter
- CLK  input  1  clock, all state updates on rising edge
- RSTn  input  1  reset, asynchronous, active-low
- ForwardA, ForwardB  input  2 each  ALU-operand forward codes
- BranchForwardA, BranchForwardB  input  2 each  branch-compare forward codes
- Redirect  input  1  taken branch/jump resolved in EX this cycle
- MemReq  input  1  load/store in MEM stage this cycle
- MemReady  input  1  data memory completes access this cycle
- PCWrite  output  1  PC register enable
- IFIDWrite, IDEXWrite, EXMEMWrite, MEMWBWrite  output  1 each  pipeline register enables
- FlushIFID, FlushIDEX  output  1 each  load NOP into register on next edge
- BubbleEXMEM  output  1  load NOP into EX/MEM on next edge
- CycleCnt, StallCnt, FlushCnt  output  CNT_W each  performance counters

## Operation
- `load_use` = any of the four forward codes equals 2'b11.
- FSM states: RUN, LU_STALL, MEM_WAIT. Reset state is RUN.
- **RUN** (default outputs): all write enables 1, flushes 0, bubble 0.
  - If MemReq && !MemReady: go to MEM_WAIT. All write enables are 0 this cycle (full freeze).
  - Else if Redirect: FlushIFID=1, FlushIDEX=1; stay in RUN.
  - Else if load_use: PCWrite=IFIDWrite=IDEXWrite=0, BubbleEXMEM=1, EXMEMWrite=1, MEMWBWrite=1; go to LU_STALL.
- **LU_STALL** (lasts exactly one cycle): default outputs, with load_use masked. Transition to RUN, or to MEM_WAIT under the same MemReq rule as RUN.
- **MEM_WAIT**: all write enables 0, flushes 0, bubble 0.
  - Leave to RUN on the first cycle MemReady=1. That cycle drives default outputs.
  - Redirect and load_use are ignored while waiting. The frozen EX instruction re-presents them in RUN.
- **Priority within a cycle:** memory freeze > Redirect > load_use. Redirect kills the younger instruction that raised load_use, so no stall is taken.
- **Counters:**
  - CycleCnt increments every cycle out of reset.
  - StallCnt increments on each cycle with PCWrite=0.
  - FlushCnt increments on each cycle with FlushIDEX=1.
  - All three saturate at 2^CNT_W−1 (no wrap).

## Timing
- All control outputs are combinational from the current state and inputs, valid in the same cycle. Only state and counters are registered.
- While RSTn=0 (asynchronous):
  - State=RUN and all counters=0.
  - PCWrite and all *Write outputs forced to 0.
  - FlushIFID=FlushIDEX=BubbleEXMEM=1.
- First rising edge after RSTn rises: CycleCnt becomes 1.
- A load-use hazard costs exactly 1 cycle. A memory wait costs N cycles, where N is the number of cycles with MemReady=0.
- If RSTn is asserted mid-stall or mid-wait, the FSM returns immediately to RUN and nothing is retained.
- MemReq with MemReady=1 in the same cycle means no stall.
- A load_use pulse in LU_STALL must never produce a second stall (masked by state).

## Structure
- Shared package `pipe_pkg`:
  - Forward code constants FWD_NONE=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10, FWD_LOAD=2'b11.
  - FSM state encoding.
  - CNT_W default.
- Sub-module `sat_counter` (parameter W, inputs inc/RSTn/CLK, output count), instantiated three times.

## Test plan
- **Reset:** hold RSTn=0 three cycles → PCWrite=0, FlushIFID=1, counters 0. Release → CycleCnt=1 after the first edge.
- **Load-use:** ForwardA=2'b11 for one cycle in RUN → that cycle PCWrite=0, BubbleEXMEM=1. Next cycle outputs are default; StallCnt=1.
- **Persistent code:** ForwardB=2'b11 held for two cycles → exactly one stall cycle (masked in LU_STALL); StallCnt=1.
- **Redirect vs load-use:** Redirect=1 and BranchForwardA=2'b11 in the same cycle → FlushIFID=FlushIDEX=1, PCWrite=1, no stall; FlushCnt=1, StallCnt=0.
- **Memory wait:** MemReq=1 with MemReady=0 for 4 cycles, then 1 → all enables 0 for 4 cycles, RUN on the 5th; StallCnt=4. Pulse Redirect during the wait → ignored.
- **Saturation:** CNT_W=4, run 20 cycles → CycleCnt=15 and holds. Async reset mid-MEM_WAIT → immediate RUN, counters 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: forward codes, hazard FSM encoding and the
// control-output bundle driven by hazard_ctrl.
package pipe_pkg;

  localparam int CNT_W_DEF = 32;

  localparam logic [1:0] FWD_NONE  = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;
  localparam logic [1:0] FWD_LOAD  = 2'b11;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_LU_STALL = 2'd1;
  localparam logic [1:0] ST_MEM_WAIT = 2'd2;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic idex_write;
    logic exmem_write;
    logic memwb_write;
    logic flush_ifid;
    logic flush_idex;
    logic bubble_exmem;
  } ctrl_t;

  localparam ctrl_t CTRL_RUN      = 8'b1111_1000;
  localparam ctrl_t CTRL_REDIRECT = 8'b1111_1110;
  localparam ctrl_t CTRL_LOAD_USE = 8'b0001_1001;
  localparam ctrl_t CTRL_FREEZE   = 8'b0000_0000;
  localparam ctrl_t CTRL_RESET    = 8'b0000_0111;

  function automatic logic is_load_fwd(input logic [1:0] code);
    return code == FWD_LOAD;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the hazard performance counters.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         RSTn,
  input  logic         inc,
  output logic [W-1:0] count
);

  // NOTE: sequential state is always written with <= so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, memory-wait freeze and
// redirect flush, plus cycle/stall/flush performance counters.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic [1:0]       ForwardA,
  input  logic [1:0]       ForwardB,
  input  logic [1:0]       BranchForwardA,
  input  logic [1:0]       BranchForwardB,
  input  logic             Redirect,
  input  logic             MemReq,
  input  logic             MemReady,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IDEXWrite,
  output logic             EXMEMWrite,
  output logic             MEMWBWrite,
  output logic             FlushIFID,
  output logic             FlushIDEX,
  output logic             BubbleEXMEM,
  output logic [CNT_W-1:0] CycleCnt,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  logic [1:0] state;
  logic [1:0] next_state;
  ctrl_t      ctrl;
  logic       load_use;
  logic       mem_stall;

  assign load_use  = is_load_fwd(ForwardA) || is_load_fwd(ForwardB) ||
                     is_load_fwd(BranchForwardA) || is_load_fwd(BranchForwardB);
  assign mem_stall = MemReq && !MemReady;

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    ctrl       = CTRL_RUN;
    next_state = ST_RUN;
    case (state)
      ST_MEM_WAIT: begin
        // Redirect/load_use are re-presented by the frozen EX instruction later.
        if (!MemReady) begin
          ctrl       = CTRL_FREEZE;
          next_state = ST_MEM_WAIT;
        end
      end
      default: begin
        if (mem_stall) begin
          ctrl       = CTRL_FREEZE;
          next_state = ST_MEM_WAIT;
        end else if (Redirect) begin
          ctrl = CTRL_REDIRECT;
        end else if (load_use && (state == ST_RUN)) begin
          // In LU_STALL the code is stale; forwarding flips to MEM/WB next.
          ctrl       = CTRL_LOAD_USE;
          next_state = ST_LU_STALL;
        end
      end
    endcase
    if (!RSTn) begin
      ctrl = CTRL_RESET;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state <= ST_RUN;
    end else begin
      state <= next_state;
    end
  end

  assign PCWrite     = ctrl.pc_write;
  assign IFIDWrite   = ctrl.ifid_write;
  assign IDEXWrite   = ctrl.idex_write;
  assign EXMEMWrite  = ctrl.exmem_write;
  assign MEMWBWrite  = ctrl.memwb_write;
  assign FlushIFID   = ctrl.flush_ifid;
  assign FlushIDEX   = ctrl.flush_idex;
  assign BubbleEXMEM = ctrl.bubble_exmem;

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .CLK   (CLK),
    .RSTn  (RSTn),
    .inc   (1'b1),
    .count (CycleCnt)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .RSTn  (RSTn),
    .inc   (!ctrl.pc_write),
    .count (StallCnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .CLK   (CLK),
    .RSTn  (RSTn),
    .inc   (ctrl.flush_idex),
    .count (FlushCnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios then random traffic,
// checked against a flag-based behavioural model; a CNT_W=4 copy shows saturation.
module tb_hazard_ctrl;

  logic       CLK = 1'b0;
  logic       RSTn = 1'b0;
  logic [1:0] ForwardA = '0, ForwardB = '0, BranchForwardA = '0, BranchForwardB = '0;
  logic       Redirect = 1'b0, MemReq = 1'b0, MemReady = 1'b0;

  logic        PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, MEMWBWrite;
  logic        FlushIFID, FlushIDEX, BubbleEXMEM;
  logic [31:0] CycleCnt, StallCnt, FlushCnt;

  logic        pc4, ifid4, idex4, exmem4, memwb4, fifid4, fidex4, bub4;
  logic [3:0]  cyc4, stall4, flush4;

  hazard_ctrl dut (
    .CLK(CLK), .RSTn(RSTn),
    .ForwardA(ForwardA), .ForwardB(ForwardB),
    .BranchForwardA(BranchForwardA), .BranchForwardB(BranchForwardB),
    .Redirect(Redirect), .MemReq(MemReq), .MemReady(MemReady),
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IDEXWrite(IDEXWrite),
    .EXMEMWrite(EXMEMWrite), .MEMWBWrite(MEMWBWrite),
    .FlushIFID(FlushIFID), .FlushIDEX(FlushIDEX), .BubbleEXMEM(BubbleEXMEM),
    .CycleCnt(CycleCnt), .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );

  hazard_ctrl #(.CNT_W(4)) dut4 (
    .CLK(CLK), .RSTn(RSTn),
    .ForwardA(ForwardA), .ForwardB(ForwardB),
    .BranchForwardA(BranchForwardA), .BranchForwardB(BranchForwardB),
    .Redirect(Redirect), .MemReq(MemReq), .MemReady(MemReady),
    .PCWrite(pc4), .IFIDWrite(ifid4), .IDEXWrite(idex4),
    .EXMEMWrite(exmem4), .MEMWBWrite(memwb4),
    .FlushIFID(fifid4), .FlushIDEX(fidex4), .BubbleEXMEM(bub4),
    .CycleCnt(cyc4), .StallCnt(stall4), .FlushCnt(flush4)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0]  ctrl;
    logic [31:0] cyc, stall, flush;
    logic [31:0] cyc4, stall4, flush4;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model: a pending memory wait and whether a stall was just taken.
  bit     waiting = 0;
  bit     stall_taken = 0;
  longint m_cyc = 0, m_stall = 0, m_flush = 0;
  longint m_cyc4 = 0, m_stall4 = 0, m_flush4 = 0;

  function automatic longint bump(input longint v, input longint max_v, input bit en);
    return (en && v < max_v) ? v + 1 : v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic drive(input bit rst, input logic [1:0] fa, input logic [1:0] fb,
                       input logic [1:0] bfa, input logic [1:0] bfb,
                       input bit red, input bit req, input bit rdy);
    exp_t e;
    bit lu;
    bit pc, ifid, idex, exmem, memwb, fi, fx, bub;
    RSTn = rst; ForwardA = fa; ForwardB = fb; BranchForwardA = bfa; BranchForwardB = bfb;
    Redirect = red; MemReq = req; MemReady = rdy;
    lu = (fa == 2'b11) || (fb == 2'b11) || (bfa == 2'b11) || (bfb == 2'b11);
    {pc, ifid, idex, exmem, memwb, fi, fx, bub} = 8'b1111_1000;
    if (!rst) begin
      {pc, ifid, idex, exmem, memwb, fi, fx, bub} = 8'b0000_0111;
      waiting = 0; stall_taken = 0;
      m_cyc = 0; m_stall = 0; m_flush = 0; m_cyc4 = 0; m_stall4 = 0; m_flush4 = 0;
    end else if (waiting) begin
      if (!rdy) {pc, ifid, idex, exmem, memwb} = 5'b0;
      else waiting = 0;
      stall_taken = 0;
    end else if (req && !rdy) begin
      {pc, ifid, idex, exmem, memwb} = 5'b0;
      waiting = 1; stall_taken = 0;
    end else if (red) begin
      fi = 1; fx = 1; stall_taken = 0;
    end else if (lu && !stall_taken) begin
      pc = 0; ifid = 0; idex = 0; bub = 1; stall_taken = 1;
    end else begin
      stall_taken = 0;
    end
    e.ctrl  = {pc, ifid, idex, exmem, memwb, fi, fx, bub};
    e.cyc   = 32'(m_cyc);  e.stall  = 32'(m_stall);  e.flush  = 32'(m_flush);
    e.cyc4  = 32'(m_cyc4); e.stall4 = 32'(m_stall4); e.flush4 = 32'(m_flush4);
    sb.push_back(e);
    if (rst) begin
      m_cyc    = bump(m_cyc,    64'hFFFF_FFFF, 1'b1);
      m_stall  = bump(m_stall,  64'hFFFF_FFFF, !pc);
      m_flush  = bump(m_flush,  64'hFFFF_FFFF, fx);
      m_cyc4   = bump(m_cyc4,   15, 1'b1);
      m_stall4 = bump(m_stall4, 15, !pc);
      m_flush4 = bump(m_flush4, 15, fx);
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("ctrl", {24'b0, PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, MEMWBWrite,
                     FlushIFID, FlushIDEX, BubbleEXMEM}, {24'b0, e.ctrl});
      check("ctrl4", {24'b0, pc4, ifid4, idex4, exmem4, memwb4, fifid4, fidex4, bub4},
            {24'b0, e.ctrl});
      check("CycleCnt", CycleCnt, e.cyc);
      check("StallCnt", StallCnt, e.stall);
      check("FlushCnt", FlushCnt, e.flush);
      check("CycleCnt4", {28'b0, cyc4}, e.cyc4);
      check("StallCnt4", {28'b0, stall4}, e.stall4);
      check("FlushCnt4", {28'b0, flush4}, e.flush4);
    end
  end

  initial begin
    logic [1:0] f[4];
    bit rst, red, req, rdy;
    @(posedge CLK);
    #1;
    // Reset then release
    repeat (3) drive(0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    // Single-cycle load-use
    drive(1, 2'b11, 0, 0, 0, 0, 0, 0);
    drive(1, 2'b10, 0, 0, 0, 0, 0, 0);
    idle(1);
    // Persistent code: one stall only
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 2'b11, 0, 0, 0, 0, 0);
    drive(1, 0, 2'b11, 0, 0, 0, 0, 0);
    idle(1);
    // Redirect beats load-use
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 2'b11, 0, 1, 0, 0);
    idle(1);
    // Memory wait of 4 cycles with a Redirect pulse inside
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0, 1, 1, 0);
    drive(1, 0, 2'b11, 0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0, 0, 1, 1);
    drive(1, 0, 0, 0, 0, 0, 1, 1);
    // Long quiet run to saturate the 4-bit copy, then reset mid-wait
    idle(20);
    drive(1, 0, 0, 0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    idle(3);
    // Random traffic
    for (int i = 0; i < 500; i++) begin
      for (int k = 0; k < 4; k++) f[k] = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      rst = ($urandom_range(0, 149) != 0);
      red = ($urandom_range(0, 5) == 0) && !stall_taken;
      req = ($urandom_range(0, 2) == 0);
      rdy = ($urandom_range(0, 1) == 0);
      drive(rst, f[0], f[1], f[2], f[3], red, req, rdy);
    end
    idle(2);
    @(negedge CLK);
    #1;
    check("sb_drain", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
